// File: rtl/gpio_vector_seq.sv
// gpio_vector_seq: pattern sequencer for the 32-bit GPIO vector.
// Plays up to DEPTH stored words onto seq_out at a programmable step period,
// with an iomem/Wishbone-style register page for control and pattern storage.
// Optional feature macro: GPIO_SEQ_CAPTURE_EN builds the per-step input capture
// registers; without it CAPTURE reads return 0 and gpio_vector_in is unused.
module gpio_vector_seq #(
    parameter logic [31:0] BASE_ADR  = 32'h2100_0100,
    parameter int          DEPTH     = 8,
    parameter int          DIV_WIDTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] iomem_addr,
    input  logic        iomem_valid,
    input  logic        iomem_wstrb,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    input  logic [31:0] gpio_vector_in,
    output logic [31:0] seq_out,
    output logic        seq_active,
    output logic        seq_irq
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_W = 5'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     len_q, len_d;
    logic [IDX_W-1:0]     idx_inc;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 loop_q, loop_d;
    logic                 irq_en_q, irq_en_d;
    logic                 done_q, done_d;
    logic [31:0]          seq_out_q, seq_out_d;
    logic                 ready_q;
    logic [31:0]          rdata_q, rdata_d;
    logic [31:0]          pattern_q [DEPTH];
    logic [31:0]          cap_rd;
    logic                 cap_we;
    logic                 unused_bits;

    logic                 page_hit;
    logic                 access;
    logic                 bus_wr;
    logic                 bus_rd;
    logic [5:0]           word_off;
    logic [IDX_W-1:0]     word_idx;
    logic                 word_in_range;
    logic                 sel_ctrl, sel_div, sel_len, sel_step, sel_pat, sel_cap;
    logic                 start_cmd, stop_cmd;
    logic                 busy;

    // A request is only taken when the previous acknowledge has finished,
    // which enforces the one-access-per-two-cycles bus rhythm.
    assign page_hit      = (iomem_addr[31:8] == BASE_ADR[31:8]);
    assign access        = iomem_valid && page_hit && !ready_q;
    assign bus_wr        = access && iomem_wstrb;
    assign bus_rd        = access && !iomem_wstrb;
    assign word_off      = iomem_addr[7:2];
    assign word_idx      = iomem_addr[2 +: IDX_W];
    assign word_in_range = ({1'b0, word_off[3:0]} < DEPTH_W);

    assign sel_ctrl = (word_off == 6'h00);
    assign sel_div  = (word_off == 6'h01);
    assign sel_len  = (word_off == 6'h02);
    assign sel_step = (word_off == 6'h03);
    assign sel_pat  = (word_off[5:4] == 2'b01) && word_in_range;
    assign sel_cap  = (word_off[5:4] == 2'b10) && word_in_range;

    // STOP has priority over START when both bits arrive in one write.
    assign start_cmd = bus_wr && sel_ctrl && iomem_wdata[0] && !iomem_wdata[1];
    assign stop_cmd  = bus_wr && sel_ctrl && iomem_wdata[1];
    assign busy      = (state_q == ST_RUN);
    assign idx_inc   = idx_q + IDX_W'(1);

    // Next-state logic for the sequencer and its control registers.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        seq_out_d = seq_out_q;
        div_d     = div_q;
        len_d     = len_q;
        loop_d    = loop_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        cap_we    = 1'b0;

        if (bus_wr && sel_ctrl) begin
            loop_d   = iomem_wdata[2];
            irq_en_d = iomem_wdata[3];
            if (iomem_wdata[5]) begin
                done_d = 1'b0;
            end
        end
        if (bus_wr && sel_div && !busy) begin
            div_d = iomem_wdata[DIV_WIDTH-1:0];
        end
        if (bus_wr && sel_len && !busy) begin
            len_d = iomem_wdata[IDX_W-1:0];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_cmd) begin
                    state_d   = ST_RUN;
                    idx_d     = '0;
                    seq_out_d = pattern_q[0];
                    cnt_d     = div_q;
                    done_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop_cmd) begin
                    state_d = ST_IDLE;
                end else if (start_cmd) begin
                    idx_d     = '0;
                    seq_out_d = pattern_q[0];
                    cnt_d     = div_q;
                    done_d    = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end else begin
                    cap_we = 1'b1;
                    if (idx_q < len_q) begin
                        idx_d     = idx_inc;
                        seq_out_d = pattern_q[idx_inc];
                        cnt_d     = div_q;
                    end else if (loop_q) begin
                        idx_d     = '0;
                        seq_out_d = pattern_q[0];
                        cnt_d     = div_q;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data mux; data is presented together with the acknowledge.
    always_comb begin
        rdata_d = '0;
        if (bus_rd) begin
            if (sel_ctrl) begin
                rdata_d = {26'b0, done_q, busy, irq_en_q, loop_q, 2'b00};
            end else if (sel_div) begin
                rdata_d = 32'(div_q);
            end else if (sel_len) begin
                rdata_d = 32'(len_q);
            end else if (sel_step) begin
                rdata_d = 32'(idx_q);
            end else if (sel_pat) begin
                rdata_d = pattern_q[word_idx];
            end else if (sel_cap) begin
                rdata_d = cap_rd;
            end
        end
    end

    // Sequencer, control and bus-handshake registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            seq_out_q <= '0;
            div_q     <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            seq_out_q <= seq_out_d;
            div_q     <= div_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            ready_q   <= access;
            rdata_q   <= rdata_d;
        end
    end

    // Pattern storage; writes are accepted even while running and are picked
    // up the next time that entry is loaded onto the vector.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pattern_q[i] <= '0;
            end
        end else if (bus_wr && sel_pat) begin
            pattern_q[word_idx] <= iomem_wdata;
        end
    end

`ifdef GPIO_SEQ_CAPTURE_EN
    logic [31:0] capture_q [DEPTH];

    // Sample the pad vector into the slot of the step that is ending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                capture_q[i] <= '0;
            end
        end else if (cap_we) begin
            capture_q[idx_q] <= gpio_vector_in;
        end
    end

    assign cap_rd      = capture_q[word_idx];
    assign unused_bits = ^iomem_addr[1:0];
`else
    assign cap_rd      = '0;
    assign unused_bits = ^{iomem_addr[1:0], gpio_vector_in, cap_we};
`endif

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign seq_out     = seq_out_q;
    assign seq_active  = (state_q == ST_RUN);
    assign seq_irq     = done_q & irq_en_q;

endmodule

// File: tb/tb_gpio_vector_seq.sv
// tb_gpio_vector_seq: directed self-checking bench for gpio_vector_seq.
// Honours GPIO_SEQ_CAPTURE_EN for the expected CAPTURE read values.
module tb_gpio_vector_seq;

    localparam logic [31:0] BASE = 32'h2100_0100;
    localparam logic [31:0] A0   = 32'hA0A0_1111;
    localparam logic [31:0] A1   = 32'hA1A1_2222;
    localparam logic [31:0] A2   = 32'hA2A2_3333;
    localparam logic [31:0] A3   = 32'hA3A3_4444;
    localparam logic [31:0] P5   = 32'h5555_AAAA;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] iomem_addr;
    logic        iomem_valid;
    logic        iomem_wstrb;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        iomem_ready;
    logic [31:0] gpio_vector_in;
    logic [31:0] seq_out;
    logic        seq_active;
    logic        seq_irq;

    int          assertCount = 0;
    int          failCount   = 0;
    logic [31:0] rdData;
    logic [31:0] expWord;
    logic        sawReady;

    gpio_vector_seq dut (
        .clk            (clk),
        .resetn         (resetn),
        .iomem_addr     (iomem_addr),
        .iomem_valid    (iomem_valid),
        .iomem_wstrb    (iomem_wstrb),
        .iomem_wdata    (iomem_wdata),
        .iomem_rdata    (iomem_rdata),
        .iomem_ready    (iomem_ready),
        .gpio_vector_in (gpio_vector_in),
        .seq_out        (seq_out),
        .seq_active     (seq_active),
        .seq_irq        (seq_irq)
    );

    always #5 clk = ~clk;

    // One comparison point: count it, and on mismatch count and report.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // One bus access; returns at 1ns after the acknowledging edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata);
        logic gotAck;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_wstrb = wr;
        iomem_addr  = addr;
        iomem_wdata = wdata;
        gotAck      = 1'b0;
        rdata       = '0;
        for (int i = 0; i < 4 && !gotAck; i++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) begin
                gotAck = 1'b1;
                rdata  = iomem_rdata;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 1'b0;
        checkOutput("busAck", 32'(gotAck), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetn         = 1'b0;
        iomem_addr     = '0;
        iomem_valid    = 1'b0;
        iomem_wstrb    = 1'b0;
        iomem_wdata    = '0;
        gpio_vector_in = '0;
        $display("[TB] reset and idle");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstSeqOut", seq_out, 32'h0);
        checkOutput("rstActive", 32'(seq_active), 32'd0);
        checkOutput("rstIrq", 32'(seq_irq), 32'd0);
        checkOutput("rstReady", 32'(iomem_ready), 32'd0);
        checkOutput("rstRdata", iomem_rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        applyStimulus(1'b0, BASE + 32'h00, 32'h0, rdData);
        checkOutput("ctrlReset", rdData, 32'h0);
        applyStimulus(1'b0, BASE + 32'h04, 32'h0, rdData);
        checkOutput("divReset", rdData, 32'h0);

        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_wstrb = 1'b0;
        iomem_addr  = 32'h2100_0200;
        sawReady    = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (iomem_ready) sawReady = 1'b1;
        end
        iomem_valid = 1'b0;
        checkOutput("outOfPageNoAck", 32'(sawReady), 32'd0);

        applyStimulus(1'b1, BASE + 32'h10, 32'h1234_5678, rdData);
        applyStimulus(1'b0, BASE + 32'h10, 32'h0, rdData);
        checkOutput("unmappedRead", rdData, 32'h0);

        $display("[TB] basic run");
        applyStimulus(1'b1, BASE + 32'h40, A0, rdData);
        applyStimulus(1'b1, BASE + 32'h44, A1, rdData);
        applyStimulus(1'b1, BASE + 32'h48, A2, rdData);
        applyStimulus(1'b1, BASE + 32'h4C, A3, rdData);
        applyStimulus(1'b1, BASE + 32'h08, 32'd3, rdData);
        applyStimulus(1'b1, BASE + 32'h04, 32'd2, rdData);
        applyStimulus(1'b0, BASE + 32'h48, 32'h0, rdData);
        checkOutput("patternReadback", rdData, A2);
        applyStimulus(1'b0, BASE + 32'h08, 32'h0, rdData);
        checkOutput("lenReadback", rdData, 32'd3);

        applyStimulus(1'b1, BASE + 32'h00, 32'h1, rdData);
        checkOutput("startReadyCycle", 32'(iomem_ready), 32'd1);
        checkOutput("startSeqOut", seq_out, A0);
        checkOutput("startActive", 32'(seq_active), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            expWord = (k < 3) ? A0 : (k < 6) ? A1 : (k < 9) ? A2 : A3;
            checkOutput("basicSeqOut", seq_out, expWord);
            checkOutput("basicActive", 32'(seq_active), (k < 12) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, BASE + 32'h00, 32'h0, rdData);
        checkOutput("basicCtrlDone", rdData, 32'h20);
        checkOutput("basicIrqMasked", 32'(seq_irq), 32'd0);
        applyStimulus(1'b0, BASE + 32'h0C, 32'h0, rdData);
        checkOutput("basicStepHold", rdData, 32'd3);

        $display("[TB] capture run");
        applyStimulus(1'b1, BASE + 32'h08, 32'd7, rdData);
        applyStimulus(1'b1, BASE + 32'h04, 32'd0, rdData);
        applyStimulus(1'b1, BASE + 32'h00, 32'h1, rdData);
        gpio_vector_in = 32'h0;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk);
            #1;
            gpio_vector_in = 32'h1111_1111 * n;
        end
        @(posedge clk);
        #1;
        gpio_vector_in = 32'h0;
        checkOutput("captureRunDone", 32'(seq_active), 32'd0);
        applyStimulus(1'b0, BASE + 32'h00, 32'h0, rdData);
        checkOutput("captureCtrlDone", rdData, 32'h20);
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b0, BASE + 32'h80 + 32'(4 * n), 32'h0, rdData);
`ifdef GPIO_SEQ_CAPTURE_EN
            expWord = 32'h1111_1111 * n;
`else
            expWord = 32'h0;
`endif
            checkOutput("captureWord", rdData, expWord);
        end

        $display("[TB] loop and stop");
        applyStimulus(1'b1, BASE + 32'h08, 32'd1, rdData);
        applyStimulus(1'b1, BASE + 32'h04, 32'd4, rdData);
        applyStimulus(1'b1, BASE + 32'h00, 32'h5, rdData);
        checkOutput("loopStartSeqOut", seq_out, A0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            expWord = (((k / 5) % 2) == 1) ? A1 : A0;
            checkOutput("loopSeqOut", seq_out, expWord);
            checkOutput("loopActive", 32'(seq_active), 32'd1);
        end
        applyStimulus(1'b0, BASE + 32'h00, 32'h0, rdData);
        checkOutput("loopCtrlBusy", rdData, 32'h14);
        applyStimulus(1'b1, BASE + 32'h00, 32'h2, rdData);
        checkOutput("stopActive", 32'(seq_active), 32'd0);
        checkOutput("stopIrq", 32'(seq_irq), 32'd0);
        applyStimulus(1'b0, BASE + 32'h00, 32'h0, rdData);
        checkOutput("stopCtrlNoDone", rdData, 32'h0);

        $display("[TB] restart and lock");
        applyStimulus(1'b1, BASE + 32'h54, P5, rdData);
        applyStimulus(1'b1, BASE + 32'h08, 32'd7, rdData);
        applyStimulus(1'b1, BASE + 32'h04, 32'd3, rdData);
        applyStimulus(1'b1, BASE + 32'h00, 32'h1, rdData);
        applyStimulus(1'b1, BASE + 32'h04, 32'd9, rdData);
        applyStimulus(1'b0, BASE + 32'h04, 32'h0, rdData);
        checkOutput("divLockedWhileBusy", rdData, 32'd3);
        repeat (17) @(posedge clk);
        #1;
        checkOutput("index5SeqOut", seq_out, P5);
        applyStimulus(1'b1, BASE + 32'h00, 32'h1, rdData);
        checkOutput("restartSeqOut", seq_out, A0);
        checkOutput("restartActive", 32'(seq_active), 32'd1);
        applyStimulus(1'b0, BASE + 32'h0C, 32'h0, rdData);
        checkOutput("restartStep", rdData, 32'd0);
        applyStimulus(1'b1, BASE + 32'h00, 32'h2, rdData);

        $display("[TB] irq");
        applyStimulus(1'b1, BASE + 32'h08, 32'd0, rdData);
        applyStimulus(1'b1, BASE + 32'h04, 32'd0, rdData);
        applyStimulus(1'b1, BASE + 32'h00, 32'h9, rdData);
        checkOutput("irqStartLow", 32'(seq_irq), 32'd0);
        checkOutput("irqStartActive", 32'(seq_active), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("irqRaised", 32'(seq_irq), 32'd1);
        checkOutput("irqRunEnded", 32'(seq_active), 32'd0);
        checkOutput("irqSeqOutHold", seq_out, A0);
        applyStimulus(1'b1, BASE + 32'h00, 32'h28, rdData);
        checkOutput("irqCleared", 32'(seq_irq), 32'd0);
        applyStimulus(1'b0, BASE + 32'h00, 32'h0, rdData);
        checkOutput("irqCtrlAfterClear", rdData, 32'h08);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, BASE + 32'h08, 32'd7, rdData);
        applyStimulus(1'b1, BASE + 32'h04, 32'd3, rdData);
        applyStimulus(1'b1, BASE + 32'h00, 32'h5, rdData);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("asyncResetActive", 32'(seq_active), 32'd0);
        checkOutput("asyncResetSeqOut", seq_out, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b0, BASE + 32'h00, 32'h0, rdData);
        checkOutput("postResetCtrl", rdData, 32'h0);
        applyStimulus(1'b0, BASE + 32'h40, 32'h0, rdData);
        checkOutput("postResetPattern", rdData, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/gpio_vector_seq.md
# gpio_vector_seq

Pattern sequencer for the 32-bit GPIO vector: stores up to DEPTH output words and plays them onto the vector at a programmable step period, optionally sampling the vector inputs at the end of each step. Sits on the iomem/Wishbone bus beside the GPIO vector controller. While running, its output word replaces the CPU-written vector data through an external mux selected by `seq_active`.

## Interface
- `BASE_ADR`, 32'h2100_0100, bus page; address bits [31:8] must match.
- `DEPTH`, 8, pattern entries; power of two, 2..16.
- `DIV_WIDTH`, 16, width of step-period divider.
- `clk` in 1: bus and sequencer clock.
- `resetn` in 1: reset; asynchronous, active-low.
- `iomem_addr` in 32: byte address.
- `iomem_valid` in 1: request.
- `iomem_wstrb` in 1: write when 1, read when 0.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid with `iomem_ready`.
- `iomem_ready` out 1: one-cycle acknowledge.
- `gpio_vector_in` in 32: pad input vector.
- `seq_out` out 32: sequenced output word.
- `seq_active` out 1: sequencer owns the vector.
- `seq_irq` out 1: level interrupt.

## Operation
- Register offsets (addr[7:0]):
  - 0x00 CTRL: bit0 START (W, self-clearing), bit1 STOP (W), bit2 LOOP, bit3 IRQ_EN; bit4 BUSY (RO); bit5 DONE (sticky, write 1 clears).
  - 0x04 DIV: step length minus 1.
  - 0x08 LEN: steps minus 1, log2(DEPTH) bits.
  - 0x0C STEP: current index (RO).
  - 0x40+4n PATTERN[n]: R/W.
  - 0x80+4n CAPTURE[n]: RO.
  - Other in-page offsets: ack, read 0, writes ignored. Out-of-page: no ack.
- States: IDLE, RUN.
- IDLE -> RUN on START:
  - index=0, `seq_out`=PATTERN[0], counter=DIV, `seq_active`=1, DONE cleared.
- RUN, counter>0: decrement.
- RUN, counter==0:
  - CAPTURE[index] <= `gpio_vector_in`.
  - If index<LEN: index+1, `seq_out`=PATTERN[index+1], reload counter.
  - If index==LEN and LOOP: index=0, `seq_out`=PATTERN[0], reload counter.
  - If index==LEN and no LOOP: go to IDLE, DONE=1, `seq_active`=0, `seq_out` holds last word.
- STOP in RUN: go to IDLE next edge; DONE not set; no capture for the partial step.
- START and STOP in the same write: STOP wins.
- START while RUN: restart from index 0.
- DIV/LEN writes while BUSY are ignored. PATTERN writes while BUSY are allowed and take effect at that entry's next load.
- `seq_irq` = DONE & IRQ_EN.
- Reset value of every output and register: 0. Reset mid-run aborts immediately; `seq_active` drops asynchronously.

## Timing
- Bus: `iomem_ready` pulses high the cycle after `valid` is sampled with a matching page and ready low; one access per two cycles minimum. `iomem_rdata` is registered with ready.
- START takes effect on the acknowledging edge: `seq_out`/`seq_active` update in the same cycle `iomem_ready` is high.
- Each step lasts DIV+1 clocks. DIV=0 gives a new word every clock.
- Capture samples at the clock edge that ends the step. The captured data is readable the following cycle.
- A non-loop run of LEN+1 steps sets DONE (DIV+1)*(LEN+1) clocks after START is acknowledged.

## Configuration
- `GPIO_SEQ_CAPTURE_EN` defined: CAPTURE registers and per-step sampling are built.
- Undefined: no capture storage; 0x80+ reads return 0; `gpio_vector_in` is unused. All other behaviour is identical.

## Test plan
- Reset and idle: after reset, all outputs are 0. Read CTRL -> 0. Out-of-page access -> no `iomem_ready`.
- Basic run: PATTERN[0..3]=A0..A3, LEN=3, DIV=2, START -> `seq_out` steps A0..A3 every 3 clocks. DONE sets 12 clocks after ack. `seq_active` falls and `seq_out` stays A3.
- Capture: `gpio_vector_in`=step index×0x11111111, LEN=7, DIV=0 -> CAPTURE[n] = n×0x11111111 (skip when macro is off and expect 0).
- Loop and stop: LOOP=1, LEN=1, DIV=4 -> alternates indefinitely with DONE=0. STOP mid-step -> IDLE next edge, DONE=0, `seq_irq`=0.
- Restart and lock: START while RUN at index 5 -> index 0 next edge. A DIV write while BUSY reads back the old value.
- IRQ: IRQ_EN=1, single step -> `seq_irq` high at completion. Writing CTRL bit5=1 -> `seq_irq` low next cycle.
